// File: rtl/maxim_pkg.sv
// Shared types and constants for the maxim frame peak sequencer.
// Optional argmax tracking is enabled by defining MAXIM_ARGMAX_EN.
package maxim_pkg;

  localparam int W_DEF  = 4;
  localparam int CW_DEF = 8;
  localparam int LANES  = 4;
  localparam int LANE_W = $clog2(LANES);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/maxim_frame_ctrl_if.sv
// Beat input and frame result handshake bundle for maxim_frame_ctrl.
// master = producer/consumer side, slave = the frame controller.
interface maxim_frame_ctrl_if
  import maxim_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int CW = CW_DEF
);

  logic          in_valid;
  logic          in_ready;
  logic          in_last;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [W-1:0]  c;
  logic [W-1:0]  d;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  q;
  logic [CW+1:0] idx;
  logic [CW-1:0] nbeats;
  logic          ovf;

  modport master (
    output in_valid, in_last, a, b, c, d, out_ready,
    input  in_ready, out_valid, q, idx, nbeats, ovf
  );

  modport slave (
    input  in_valid, in_last, a, b, c, d, out_ready,
    output in_ready, out_valid, q, idx, nbeats, ovf
  );

endinterface

// File: rtl/maxim4_core.sv
// Combinational 4-input unsigned maximizer; ties resolve to the lowest lane.
// Winning lane output exists only when MAXIM_ARGMAX_EN is defined.
module maxim4_core
  import maxim_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0]      a_i,
  input  logic [W-1:0]      b_i,
  input  logic [W-1:0]      c_i,
  input  logic [W-1:0]      d_i,
  output logic [W-1:0]      max_o
`ifdef MAXIM_ARGMAX_EN
  , output logic [LANE_W-1:0] lane_o
`endif
);

  logic [W-1:0] m01;
  logic [W-1:0] m23;

  // Strict compares everywhere so an equal higher lane never displaces a lower one.
  always_comb begin
    m01   = (b_i > a_i) ? b_i : a_i;
    m23   = (d_i > c_i) ? d_i : c_i;
    max_o = (m23 > m01) ? m23 : m01;
  end

`ifdef MAXIM_ARGMAX_EN
  always_comb begin
    lane_o = '0;
    if (m23 > m01) begin
      lane_o = (d_i > c_i) ? LANE_W'(3) : LANE_W'(2);
    end else begin
      lane_o = (b_i > a_i) ? LANE_W'(1) : LANE_W'(0);
    end
  end
`endif

endmodule

// File: rtl/maxim_frame_ctrl.sv
// Frame sequencer: per-frame running max over 4-lane beats through one shared maximizer.
// Result 2 cycles after the last beat; position tracking only with MAXIM_ARGMAX_EN.
module maxim_frame_ctrl
  import maxim_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int CW = CW_DEF
) (
  input logic               clk,
  input logic               rst_n,
  maxim_frame_ctrl_if.slave bus
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  state_e        state_q;
  logic          xfer;
  logic [W-1:0]  lane_max;
  logic          s1_vld_q;
  logic          s1_first_q;
  logic [W-1:0]  s1_max_q;
  logic          take_new;
  logic [W-1:0]  run_max_q;
  logic [W-1:0]  run_max_d;
  logic [CW-1:0] cnt_q;
  logic          ovf_q;
  logic          out_valid_q;
  logic [W-1:0]  q_q;
  logic [CW-1:0] nbeats_q;
  logic          ovf_out_q;

`ifdef MAXIM_ARGMAX_EN
  logic [LANE_W-1:0] lane_win;
  logic [LANE_W-1:0] s1_lane_q;
  logic [CW-1:0]     s1_beat_q;
  logic [CW-1:0]     beat_num;
  logic [CW+1:0]     run_idx_q;
  logic [CW+1:0]     run_idx_d;
  logic [CW+1:0]     idx_q;
`endif

  // Gating with rst_n keeps a beat from being taken during the reset cycle.
  assign bus.in_ready = rst_n && ((state_q == IDLE) || (state_q == ACCUM));
  assign xfer         = bus.in_valid && bus.in_ready;

  maxim4_core #(.W(W)) u_core (
    .a_i   (bus.a),
    .b_i   (bus.b),
    .c_i   (bus.c),
    .d_i   (bus.d),
    .max_o (lane_max)
`ifdef MAXIM_ARGMAX_EN
    , .lane_o(lane_win)
`endif
  );

  assign take_new  = s1_first_q || (s1_max_q > run_max_q);
  assign run_max_d = (s1_vld_q && take_new) ? s1_max_q : run_max_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld_q   <= 1'b0;
      s1_first_q <= 1'b0;
      s1_max_q   <= '0;
      run_max_q  <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      s1_vld_q  <= xfer;
      run_max_q <= run_max_d;
      if (xfer) begin
        s1_max_q   <= lane_max;
        s1_first_q <= (state_q == IDLE);
        if (state_q == IDLE) begin
          cnt_q <= CW'(1);
          ovf_q <= 1'b0;
        end else if (cnt_q == CNT_MAX) begin
          ovf_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

  // DRAIN is the cycle the last beat reaches stage 2, so outputs load from the _d values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      q_q         <= '0;
      nbeats_q    <= '0;
      ovf_out_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (xfer) state_q <= bus.in_last ? DRAIN : ACCUM;
        ACCUM: if (xfer && bus.in_last) state_q <= DRAIN;
        DRAIN: begin
          state_q     <= DONE;
          out_valid_q <= 1'b1;
          q_q         <= run_max_d;
          nbeats_q    <= cnt_q;
          ovf_out_q   <= ovf_q;
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
      endcase
    end
  end

`ifdef MAXIM_ARGMAX_EN
  assign beat_num  = (state_q == IDLE) ? '0 : cnt_q;
  assign run_idx_d = (s1_vld_q && take_new) ? {s1_beat_q, s1_lane_q} : run_idx_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_lane_q <= '0;
      s1_beat_q <= '0;
      run_idx_q <= '0;
      idx_q     <= '0;
    end else begin
      if (xfer) begin
        s1_lane_q <= lane_win;
        s1_beat_q <= beat_num;
      end
      run_idx_q <= run_idx_d;
      if (state_q == DRAIN) idx_q <= run_idx_d;
    end
  end

  assign bus.idx = idx_q;
`else
  assign bus.idx = '0;
`endif

  assign bus.out_valid = out_valid_q;
  assign bus.q         = q_q;
  assign bus.nbeats    = nbeats_q;
  assign bus.ovf       = ovf_out_q;

endmodule

// File: tb/tb_maxim_frame_ctrl.sv
// Randomized scoreboard bench for maxim_frame_ctrl, run on CW=8 and CW=2 instances in lockstep.
// Expected IDX follows MAXIM_ARGMAX_EN.
module tb_maxim_frame_ctrl;
  import maxim_pkg::*;

  typedef struct {
    logic [3:0] q;
    logic [9:0] idx8;
    logic [7:0] nb8;
    logic       ovf8;
    logic [3:0] idx2;
    logic [1:0] nb2;
    logic       ovf2;
    int         rise;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic out_ready = 1'b0;
  logic [3:0] a = '0, b = '0, c = '0, d = '0;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   bp_mode = 2;
  exp_t sb[$];
  exp_t e;
  bit   prev_v = 1'b0;
  bit   prev_hs = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  maxim_frame_ctrl_if #(.W(4), .CW(8)) if8 ();
  maxim_frame_ctrl_if #(.W(4), .CW(2)) if2 ();

  assign if8.in_valid = in_valid;  assign if2.in_valid = in_valid;
  assign if8.in_last  = in_last;   assign if2.in_last  = in_last;
  assign if8.a = a;  assign if8.b = b;  assign if8.c = c;  assign if8.d = d;
  assign if2.a = a;  assign if2.b = b;  assign if2.c = c;  assign if2.d = d;
  assign if8.out_ready = out_ready;  assign if2.out_ready = out_ready;

  maxim_frame_ctrl #(.W(4), .CW(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
  maxim_frame_ctrl #(.W(4), .CW(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: earliest (beat, lane) holding the frame maximum; counts saturate per CW.
  function automatic exp_t model(input bit [15:0] fr[$], input int rise);
    exp_t r;
    int mx, bk, bl, n, v;
    mx = -1; bk = 0; bl = 0; n = fr.size();
    for (int k = 0; k < n; k++) begin
      for (int l = 0; l < 4; l++) begin
        v = int'(fr[k][4*l +: 4]);
        if (v > mx) begin mx = v; bk = k; bl = l; end
      end
    end
    r.q    = 4'(mx);
    r.nb8  = 8'((n > 255) ? 255 : n);
    r.ovf8 = (n > 255);
    r.nb2  = 2'((n > 3) ? 3 : n);
    r.ovf2 = (n > 3);
`ifdef MAXIM_ARGMAX_EN
    r.idx8 = 10'(((bk > 255) ? 255 : bk) * 4 + bl);
    r.idx2 = 4'(((bk > 3) ? 3 : bk) * 4 + bl);
`else
    r.idx8 = '0;
    r.idx2 = '0;
`endif
    r.rise = rise;
    return r;
  endfunction

  function automatic bit [15:0] rnd_beat(input int lim);
    return {4'($urandom_range(0, lim)), 4'($urandom_range(0, lim)),
            4'($urandom_range(0, lim)), 4'($urandom_range(0, lim))};
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v  = 1'b0;
      prev_hs = 1'b0;
    end else begin
      if (prev_hs) chk("out_valid_drop", if8.out_valid, 0);
      if (if8.out_valid) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result: out_valid=1 with no frame pending (cycle %0d)", cyc);
        end else begin
          e = sb[0];
          if (!prev_v) chk("latency", cyc, e.rise);
          chk("q8", if8.q, e.q);          chk("q2", if2.q, e.q);
          chk("idx8", if8.idx, e.idx8);   chk("idx2", if2.idx, e.idx2);
          chk("nbeats8", if8.nbeats, e.nb8); chk("nbeats2", if2.nbeats, e.nb2);
          chk("ovf8", if8.ovf, e.ovf8);   chk("ovf2", if2.ovf, e.ovf2);
          chk("in_ready_done", if8.in_ready, 0);
          if (out_ready) void'(sb.pop_front());
        end
      end else if (sb.size() > 0 && cyc == sb[0].rise) begin
        chk("out_valid_at_latency", if8.out_valid, 1);
      end
      chk("out_valid_cw2", if2.out_valid, if8.out_valid);
      prev_hs = if8.out_valid && out_ready;
      prev_v  = if8.out_valid;
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      case (bp_mode)
        0:       out_ready = ($urandom_range(0, 2) != 0);
        1:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  task automatic send_frame(input bit [15:0] fr[$], input bit abort, input int maxgap);
    int g, wait_n, ncyc;
    bit acc;
    for (int k = 0; k < fr.size(); k++) begin
      g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      repeat (g) begin in_valid = 1'b0; @(posedge clk); #1; end
      {d, c, b, a} = fr[k];
      in_last  = !abort && (k == fr.size() - 1);
      in_valid = 1'b1;
      acc = 1'b0; wait_n = 0; ncyc = 0;
      while (!acc && wait_n < 300) begin
        @(negedge clk);
        if (if8.in_ready) begin acc = 1'b1; ncyc = cyc; end
        @(posedge clk); #1;
        wait_n++;
      end
      if (!acc) begin
        checks++; errors++;
        $display("FAIL beat_accept: beat %0d not accepted within 300 cycles", k);
        in_valid = 1'b0; in_last = 1'b0;
        return;
      end
      if (in_last) sb.push_back(model(fr, ncyc + 2));
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 3000) begin @(posedge clk); #1; n++; end
    if (sb.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain: %0d results still pending after 3000 cycles", sb.size());
      sb.delete();
    end
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid8"}, if8.out_valid, 0); chk({tag, "_valid2"}, if2.out_valid, 0);
    chk({tag, "_q8"}, if8.q, 0);             chk({tag, "_q2"}, if2.q, 0);
    chk({tag, "_idx8"}, if8.idx, 0);         chk({tag, "_idx2"}, if2.idx, 0);
    chk({tag, "_nbeats8"}, if8.nbeats, 0);   chk({tag, "_nbeats2"}, if2.nbeats, 0);
    chk({tag, "_ovf8"}, if8.ovf, 0);         chk({tag, "_ovf2"}, if2.ovf, 0);
    chk({tag, "_in_ready"}, if8.in_ready, 1);
  endtask

  bit [15:0] fr[$];
  int        n, lim;

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("in_ready_in_reset", if8.in_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1;

    fr = {16'hE25A};                        send_frame(fr, 0, 0); wait_drain();
    fr = {16'h0030, 16'hE25A, 16'h5555};    send_frame(fr, 0, 0); wait_drain();
    fr = {16'h5555, 16'h5555};              send_frame(fr, 0, 0); wait_drain();
    fr = {16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h00F0};
    send_frame(fr, 0, 0); wait_drain();

    // Held result under backpressure while the next frame's first beat waits.
    bp_mode = 1;
    @(posedge clk); #1;
    fr = {16'h1289};
    send_frame(fr, 0, 0);
    fork
      begin repeat (9) @(posedge clk); #1; bp_mode = 2; end
      begin fr = {16'h3412}; send_frame(fr, 0, 0); end
    join
    wait_drain();

    // Reset mid-frame after two beats; the following frame must not see them.
    fr = {16'hFFFF, 16'hEEEE};
    send_frame(fr, 1, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("in_ready_mid_reset", if8.in_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero("mid_reset");
    @(posedge clk); #1;
    fr = {16'h1234, 16'h0321};
    send_frame(fr, 0, 0); wait_drain();

    fr.delete();
    for (int k = 0; k < 260; k++) fr.push_back(rnd_beat(7));
    fr[200] = 16'hF000;
    send_frame(fr, 0, 0); wait_drain();

    bp_mode = 0;
    for (int f = 0; f < 150; f++) begin
      fr.delete();
      n   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(6, 20)) : int'($urandom_range(1, 5));
      lim = ($urandom_range(0, 1) == 0) ? 3 : 15;
      for (int k = 0; k < n; k++) fr.push_back(rnd_beat(lim));
      send_frame(fr, 0, 2);
    end
    bp_mode = 2;
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
